// File: rtl/sync_fifo_lvl_if.sv
// Handshake and status bundle for sync_fifo_lvl.
// The master side drives requests; the slave (the FIFO) returns data and status.
interface sync_fifo_lvl_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 3
) ();

  logic                 flush;
  logic                 wr_inc;
  logic [DataWidth-1:0] wr_data;
  logic                 rd_inc;
  logic [DataWidth-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [AddrWidth:0]   level;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output flush, wr_inc, wr_data, rd_inc,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_inc, wr_data, rd_inc,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO, depth 2^AddrWidth, with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a registered read port.
module sync_fifo_lvl #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 3,
  parameter int unsigned AfThresh  = (1 << AddrWidth) - 2,
  parameter int unsigned AeThresh  = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  sync_fifo_lvl_if.slave bus_io
);

  localparam int unsigned Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0] LvlDepth = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth:0] LvlAf    = (AddrWidth + 1)'(AfThresh);
  localparam logic [AddrWidth:0] LvlAe    = (AddrWidth + 1)'(AeThresh);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [AddrWidth:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrWidth:0]   rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   level_q, level_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic full, empty, wr_ok, rd_ok, mem_we;

  // Status decoded from the registered level only, so no input-to-flag paths.
  always_comb begin
    full  = (level_q == LvlDepth);
    empty = (level_q == '0);
    // A write into a full FIFO is fine when a read frees a slot on the same edge.
    wr_ok = bus_io.wr_inc & (~full | bus_io.rd_inc);
    rd_ok = bus_io.rd_inc & ~empty;
  end

  assign bus_io.full         = full;
  assign bus_io.empty        = empty;
  assign bus_io.almost_full  = (level_q >= LvlAf);
  assign bus_io.almost_empty = (level_q <= LvlAe);
  assign bus_io.level        = level_q;
  assign bus_io.rd_data      = rd_data_q;
  assign bus_io.rd_valid     = rd_valid_q;
  assign bus_io.overflow     = ovf_q;
  assign bus_io.underflow    = udf_q;

  // Next-state: flush clears everything except memory and rd_data, and swallows requests.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    mem_we     = 1'b0;
    if (bus_io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_data_d  = mem_q[rd_ptr_q[AddrWidth-1:0]];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (bus_io.wr_inc && !wr_ok) ovf_d = 1'b1;
      if (bus_io.rd_inc && !rd_ok) udf_d = 1'b1;
    end
  end

  // Control state with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; not reset, and reset blocks writes in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[wr_ptr_q[AddrWidth-1:0]] <= bus_io.wr_data;
    end
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl (depth 8) plus a queue-model run on a depth-2 instance.
module tb_sync_fifo_lvl;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_lvl_if #(.DataWidth(8), .AddrWidth(3)) bus ();
  sync_fifo_lvl_if #(.DataWidth(8), .AddrWidth(1)) bus2 ();

  sync_fifo_lvl #(.DataWidth(8), .AddrWidth(3), .AfThresh(6), .AeThresh(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  sync_fifo_lvl #(.DataWidth(8), .AddrWidth(1), .AfThresh(2), .AeThresh(0)) dut2 (
    .clk_i  (clk),
    .rst_i  (rst2),
    .bus_io (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic fl);
    bus.wr_inc  = wr;
    bus.wr_data = wd;
    bus.rd_inc  = rd;
    bus.flush   = fl;
    @(posedge clk);
    #1;
    bus.wr_inc = 1'b0;
    bus.rd_inc = 1'b0;
    bus.flush  = 1'b0;
  endtask

  // Pointer-derived full/empty must agree with the level-derived flags.
  logic [3:0] wp, rp;
  assign wp = dut.wr_ptr_q;
  assign rp = dut.rd_ptr_q;
  logic ptr_full, ptr_empty;
  assign ptr_full  = (wp[3] != rp[3]) && (wp[2:0] == rp[2:0]);
  assign ptr_empty = (wp == rp);

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("ptr_full", {31'd0, ptr_full}, {31'd0, bus.full});
      check_eq("ptr_empty", {31'd0, ptr_empty}, {31'd0, bus.empty});
    end
  end

  // Depth-2 queue model state.
  logic [7:0] mq [$];
  logic       m_ovf, m_udf, m_rdv;
  logic [7:0] m_rdd;

  initial begin
    logic [7:0] v;
    logic       w, r, f, rs, m_full, m_empty, wok, rok;
    logic [7:0] d;
    logic [31:0] got, exp;

    bus.wr_inc = 0; bus.rd_inc = 0; bus.flush = 0; bus.wr_data = '0;
    bus2.wr_inc = 0; bus2.rd_inc = 0; bus2.flush = 0; bus2.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;

    // Reset state
    check_eq("rst_rd_data", bus.rd_data, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_ae", bus.almost_empty, 1);
    check_eq("rst_full", bus.full, 0);
    check_eq("rst_af", bus.almost_full, 0);
    check_eq("rst_ovf", bus.overflow, 0);
    check_eq("rst_udf", bus.underflow, 0);

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i);
      step(1, v, 0, 0);
      check_eq("fill_level", bus.level, i);
      check_eq("fill_af", bus.almost_full, (i >= 6) ? 1 : 0);
      check_eq("fill_ae", bus.almost_empty, (i <= 2) ? 1 : 0);
      check_eq("fill_full", bus.full, (i == 8) ? 1 : 0);
      check_eq("fill_empty", bus.empty, 0);
    end
    check_eq("fill_ovf", bus.overflow, 0);

    // Write while full is rejected
    step(1, 8'h09, 0, 0);
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_level", bus.level, 8);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0);
      check_eq("drain_data", bus.rd_data, i);
      check_eq("drain_valid", bus.rd_valid, 1);
      check_eq("drain_level", bus.level, 8 - i);
      check_eq("drain_ae", bus.almost_empty, (8 - i <= 2) ? 1 : 0);
      check_eq("drain_empty", bus.empty, (i == 8) ? 1 : 0);
    end
    step(0, 0, 0, 0);
    check_eq("idle_valid", bus.rd_valid, 0);

    // Read while empty
    step(0, 0, 1, 0);
    check_eq("udf_set", bus.underflow, 1);
    check_eq("udf_valid", bus.rd_valid, 0);
    check_eq("udf_hold", bus.rd_data, 8'h08);

    // Simultaneous write + read at empty: no fall-through
    step(1, 8'hA5, 1, 0);
    check_eq("wr_rd_empty_level", bus.level, 1);
    check_eq("wr_rd_empty_valid", bus.rd_valid, 0);
    check_eq("wr_rd_empty_udf", bus.underflow, 1);
    step(0, 0, 1, 0);
    check_eq("a5_data", bus.rd_data, 8'hA5);
    check_eq("a5_valid", bus.rd_valid, 1);
    check_eq("a5_level", bus.level, 0);

    // Flush clears sticky flags
    step(0, 0, 0, 1);
    check_eq("flush1_ovf", bus.overflow, 0);
    check_eq("flush1_udf", bus.underflow, 0);

    // Full with simultaneous write/read for 20 cycles, across pointer wraps
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'h10 + i);
      step(1, v, 0, 0);
    end
    check_eq("stream_full", bus.full, 1);
    for (int k = 0; k < 20; k++) begin
      v = 8'(8'h18 + k);
      step(1, v, 1, 0);
      check_eq("stream_data", bus.rd_data, 8'h10 + k);
      check_eq("stream_valid", bus.rd_valid, 1);
      check_eq("stream_level", bus.level, 8);
    end
    check_eq("stream_ovf", bus.overflow, 0);

    // Build LEVEL 5 with OVERFLOW set, then flush with both requests high
    step(1, 8'hFF, 0, 0);
    check_eq("pre_flush_ovf", bus.overflow, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check_eq("pre_flush_level", bus.level, 5);
    check_eq("pre_flush_data", bus.rd_data, 8'h26);
    step(1, 8'hEE, 1, 1);
    check_eq("flush_level", bus.level, 0);
    check_eq("flush_empty", bus.empty, 1);
    check_eq("flush_ovf", bus.overflow, 0);
    check_eq("flush_udf", bus.underflow, 0);
    check_eq("flush_valid", bus.rd_valid, 0);
    check_eq("flush_hold", bus.rd_data, 8'h26);
    step(1, 8'h77, 0, 0);
    check_eq("post_flush_level", bus.level, 1);
    step(0, 0, 1, 0);
    check_eq("post_flush_data", bus.rd_data, 8'h77);
    check_eq("post_flush_empty", bus.empty, 1);

    // Depth-2 instance against a queue model, reset pulsed mid-run
    mq.delete();
    m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = 0;
    for (int c = 0; c < 400; c++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 31) == 0);
      rs = (c == 200);
      d  = 8'($urandom);
      bus2.wr_inc = w; bus2.rd_inc = r; bus2.flush = f; bus2.wr_data = d;
      rst2 = rs;
      @(posedge clk);
      #1;
      if (rs) begin
        mq.delete();
        m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = 0;
      end else if (f) begin
        mq.delete();
        m_ovf = 0; m_udf = 0; m_rdv = 0;
      end else begin
        m_full  = (mq.size() == 2);
        m_empty = (mq.size() == 0);
        wok = w & (~m_full | r);
        rok = r & ~m_empty;
        if (rok) begin
          m_rdd = mq.pop_front();
          m_rdv = 1;
        end else begin
          m_rdv = 0;
        end
        if (wok) mq.push_back(d);
        if (w && !wok) m_ovf = 1;
        if (r && !rok) m_udf = 1;
      end
      exp = {15'd0, m_rdv, m_rdd, 2'(mq.size()), (mq.size() == 2), (mq.size() == 0),
             (mq.size() >= 2), (mq.size() == 0), m_ovf, m_udf};
      got = {15'd0, bus2.rd_valid, bus2.rd_data, bus2.level, bus2.full, bus2.empty,
             bus2.almost_full, bus2.almost_empty, bus2.overflow, bus2.underflow};
      check_eq("model_d2", got, exp);
    end
    rst2 = 1'b0;
    bus2.wr_inc = 0; bus2.rd_inc = 0; bus2.flush = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
